// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit splitting accesses into word-aligned req/ack bus transactions
module mem_stage_lsu #(
  parameter int DATA_WIDTH   = 32,
  parameter int FUNCT3_WIDTH = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MemReadM,
  input  logic                    MemWriteM,
  input  logic [DATA_WIDTH-1:0]   ALUResultM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  input  logic [FUNCT3_WIDTH-1:0] funct3M,
  output logic [DATA_WIDTH-1:0]   ReadDataM,
  output logic                    StallM,
  output logic                    BusReq,
  output logic                    BusWe,
  output logic [DATA_WIDTH-1:0]   BusAddr,
  output logic [DATA_WIDTH-1:0]   BusWData,
  output logic [3:0]              BusByteEn,
  input  logic [DATA_WIDTH-1:0]   BusRData,
  input  logic                    BusAck
);
  typedef enum logic [1:0] {IDLE, REQ1, REQ2, DONE} state_t;
  state_t state, state_d;
  logic        cmd;
  logic [3:0]  en_in;
  logic [31:0] wmask;
  logic [63:0] d64;
  logic [7:0]  e8;
  logic [1:0]  o_q;
  logic [1:0]  sz_q;
  logic        zx_q;
  logic        ld_q;
  logic        split_q;
  logic [31:0] hi_wd;
  logic [3:0]  hi_be;
  logic [31:0] lo_q;
  logic [31:0] rd_hi;
  logic [31:0] rd_lo;
  logic [31:0] r;
  logic [31:0] ext;
  assign cmd   = MemReadM | MemWriteM;
  assign en_in = funct3M[1:0] == 2'b00 ? 4'b0001 : funct3M[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
  assign wmask = {{8{en_in[3]}}, {8{en_in[2]}}, {8{en_in[1]}}, {8{en_in[0]}}};
  assign d64   = {32'b0, WriteDataM & wmask} << {ALUResultM[1:0], 3'b000};
  assign e8    = {4'b0000, en_in} << ALUResultM[1:0];
  // The second beat pairs the fresh bus word with the buffered first word; an unsplit access sees zero above
  assign rd_hi = state == REQ2 ? BusRData : 32'b0;
  assign rd_lo = state == REQ2 ? lo_q : BusRData;
  assign r     = 32'({rd_hi, rd_lo} >> {o_q, 3'b000});
  assign ext   = sz_q == 2'b00 ? {{24{!zx_q & r[7]}}, r[7:0]} :
                 sz_q == 2'b01 ? {{16{!zx_q & r[15]}}, r[15:0]} : r;
  // Stall covers the command cycle and every bus cycle; held low during reset
  assign StallM = !RST && ((state == IDLE && cmd) || state == REQ1 || state == REQ2);
  // Next-state logic
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (cmd ? REQ1 : IDLE) :
              state == REQ1 ? (BusAck ? (split_q ? REQ2 : DONE) : REQ1) :
              state == REQ2 ? (BusAck ? DONE : REQ2) : IDLE;
  end
  // State, bus registers, transaction latches and load result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      BusReq    <= 1'b0;
      BusWe     <= 1'b0;
      BusAddr   <= '0;
      BusWData  <= '0;
      BusByteEn <= 4'b0;
      ReadDataM <= '0;
      o_q       <= 2'b0;
      sz_q      <= 2'b0;
      zx_q      <= 1'b0;
      ld_q      <= 1'b0;
      split_q   <= 1'b0;
      hi_wd     <= 32'b0;
      hi_be     <= 4'b0;
      lo_q      <= 32'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && cmd) begin
        BusReq    <= 1'b1;
        BusWe     <= MemWriteM;
        BusAddr   <= {ALUResultM[31:2], 2'b00};
        BusWData  <= d64[31:0];
        BusByteEn <= e8[3:0];
        hi_wd     <= d64[63:32];
        hi_be     <= e8[7:4];
        split_q   <= |e8[7:4];
        o_q       <= ALUResultM[1:0];
        sz_q      <= funct3M[1:0];
        zx_q      <= funct3M[2];
        ld_q      <= MemReadM & !MemWriteM;
      end else if (state == REQ1 && BusAck) begin
        lo_q <= BusRData;
        if (split_q) begin
          BusAddr   <= BusAddr + 32'd4;
          BusWData  <= hi_wd;
          BusByteEn <= hi_be;
        end else begin
          BusReq <= 1'b0;
          if (ld_q) ReadDataM <= ext;
        end
      end else if (state == REQ2 && BusAck) begin
        BusReq <= 1'b0;
        if (ld_q) ReadDataM <= ext;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed vector bench for mem_stage_lsu with a wait-state bus memory model
module tb_mem_stage_lsu;
  logic        CLK, RST;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  funct3M;
  logic [31:0] ReadDataM;
  logic        StallM, BusReq, BusWe;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusByteEn;
  logic        BusAck;

  mem_stage_lsu dut (
    .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
    .ReadDataM(ReadDataM), .StallM(StallM), .BusReq(BusReq), .BusWe(BusWe),
    .BusAddr(BusAddr), .BusWData(BusWData), .BusByteEn(BusByteEn),
    .BusRData(BusRData), .BusAck(BusAck)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    int          ntx;
    bit          we;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] a2;
    logic [3:0]  be2;
    logic [31:0] wd2;
    int          stall;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } tx_t;

  int n_tests = 0;
  int n_fail  = 0;
  int wait_cycles = 0;
  logic [31:0] mem [logic [31:0]];
  tx_t log_q[$];
  vec_t vecs[15];

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus memory: acks after wait_cycles idle request cycles and checks the request holds still meanwhile
  initial begin
    int cnt;
    tx_t snap;
    logic [31:0] w;
    cnt = 0;
    BusAck = 0;
    BusRData = 0;
    forever begin
      @(negedge CLK);
      if (RST || !BusReq) begin
        BusAck = 0;
        cnt = 0;
      end else begin
        if (cnt == 0) snap = '{BusAddr, BusWe, BusByteEn, BusWData};
        else begin
          chk("bus_stable_addr", BusAddr, snap.addr);
          chk("bus_stable_wdata", BusWData, snap.wd);
          chk("bus_stable_be_we", {27'b0, BusByteEn, BusWe}, {27'b0, snap.be, snap.we});
        end
        if (cnt == wait_cycles) begin
          w = mem.exists(BusAddr) ? mem[BusAddr] : 32'b0;
          BusRData = w;
          BusAck = 1;
          log_q.push_back('{BusAddr, BusWe, BusByteEn, BusWData});
          if (BusWe) begin
            for (int b = 0; b < 4; b++) if (BusByteEn[b]) w[8*b +: 8] = BusWData[8*b +: 8];
            mem[BusAddr] = w;
          end
          cnt = 0;
        end else begin
          BusAck = 0;
          cnt++;
        end
      end
    end
  end

  task automatic run_op(input vec_t v, input string tag);
    int stall;
    bit done;
    @(negedge CLK);
    MemReadM = v.rd;
    MemWriteM = v.wr;
    ALUResultM = v.addr;
    WriteDataM = v.wdata;
    funct3M = v.f3;
    wait_cycles = v.waits;
    log_q.delete();
    stall = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (StallM) begin
        stall++;
        @(negedge CLK);
      end else done = 1;
    end
    chk({tag, "_finished"}, {31'b0, done}, 32'd1);
    chk({tag, "_stall_cycles"}, stall, v.stall);
    chk({tag, "_readdata"}, ReadDataM, v.rdata);
    chk({tag, "_num_tx"}, log_q.size(), v.ntx);
    for (int i = 0; i < v.ntx && i < log_q.size(); i++) begin
      chk({tag, "_tx_addr"}, log_q[i].addr, i == 0 ? v.a1 : v.a2);
      chk({tag, "_tx_be"}, {28'b0, log_q[i].be}, {28'b0, i == 0 ? v.be1 : v.be2});
      chk({tag, "_tx_we"}, {31'b0, log_q[i].we}, {31'b0, v.we});
      if (v.we) chk({tag, "_tx_wdata"}, log_q[i].wd, i == 0 ? v.wd1 : v.wd2);
    end
    MemReadM = 0;
    MemWriteM = 0;
  endtask

  initial begin
    vec_t rv;
    //           rd wr f3      addr          wdata         w  n  we a1            be1      wd1           a2            be2      wd2           st rdata
    vecs[0]  = '{0, 1, 3'b010, 32'h00000100, 32'hDEADBEEF, 0, 1, 1, 32'h00000100, 4'b1111, 32'hDEADBEEF, 32'h0,        4'b0000, 32'h0,        2, 32'h00000000};
    vecs[1]  = '{1, 0, 3'b000, 32'h00000202, 32'h0,        0, 1, 0, 32'h00000200, 4'b0100, 32'h0,        32'h0,        4'b0000, 32'h0,        2, 32'hFFFFFFFF};
    vecs[2]  = '{1, 0, 3'b100, 32'h00000202, 32'h0,        0, 1, 0, 32'h00000200, 4'b0100, 32'h0,        32'h0,        4'b0000, 32'h0,        2, 32'h000000FF};
    vecs[3]  = '{1, 0, 3'b000, 32'h00000203, 32'h0,        0, 1, 0, 32'h00000200, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        2, 32'hFFFFFF80};
    vecs[4]  = '{1, 0, 3'b001, 32'h00000202, 32'h0,        0, 1, 0, 32'h00000200, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        2, 32'hFFFF80FF};
    vecs[5]  = '{1, 0, 3'b101, 32'h00000200, 32'h0,        0, 1, 0, 32'h00000200, 4'b0011, 32'h0,        32'h0,        4'b0000, 32'h0,        2, 32'h00007F01};
    vecs[6]  = '{0, 1, 3'b010, 32'h00000200, 32'h88776655, 0, 1, 1, 32'h00000200, 4'b1111, 32'h88776655, 32'h0,        4'b0000, 32'h0,        2, 32'h00007F01};
    vecs[7]  = '{1, 0, 3'b010, 32'h000001FE, 32'h0,        0, 2, 0, 32'h000001FC, 4'b1100, 32'h0,        32'h00000200, 4'b0011, 32'h0,        3, 32'h66554433};
    vecs[8]  = '{0, 1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 0, 2, 1, 32'hFFFFFFFC, 4'b1000, 32'hCD000000, 32'h00000000, 4'b0001, 32'h000000AB, 3, 32'h66554433};
    vecs[9]  = '{0, 1, 3'b000, 32'h00000101, 32'h12345678, 0, 1, 1, 32'h00000100, 4'b0010, 32'h00007800, 32'h0,        4'b0000, 32'h0,        2, 32'h66554433};
    vecs[10] = '{1, 0, 3'b010, 32'h00000100, 32'h0,        0, 1, 0, 32'h00000100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        2, 32'hDEAD78EF};
    vecs[11] = '{1, 1, 3'b010, 32'h00000300, 32'h11223344, 0, 1, 1, 32'h00000300, 4'b1111, 32'h11223344, 32'h0,        4'b0000, 32'h0,        2, 32'hDEAD78EF};
    vecs[12] = '{1, 0, 3'b001, 32'h00000103, 32'h0,        0, 2, 0, 32'h00000100, 4'b1000, 32'h0,        32'h00000104, 4'b0001, 32'h0,        3, 32'hFFFFF0DE};
    vecs[13] = '{1, 0, 3'b010, 32'h00000100, 32'h0,        3, 1, 0, 32'h00000100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        5, 32'hDEAD78EF};
    vecs[14] = '{1, 0, 3'b010, 32'h00000200, 32'h0,        0, 1, 0, 32'h00000200, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        2, 32'h88776655};
    mem[32'h00000200] = 32'h80FF7F01;
    mem[32'h000001FC] = 32'h44332211;
    mem[32'h00000104] = 32'h000000F0;
    RST = 1;
    MemReadM = 1;
    MemWriteM = 0;
    ALUResultM = 32'h100;
    WriteDataM = 0;
    funct3M = 3'b010;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_stall_low", {31'b0, StallM}, 32'd0);
    chk("reset_busreq", {31'b0, BusReq}, 32'd0);
    chk("reset_readdata", ReadDataM, 32'd0);
    chk("reset_busaddr", BusAddr, 32'd0);
    chk("reset_be_we", {27'b0, BusByteEn, BusWe}, 32'd0);
    MemReadM = 0;
    @(negedge CLK);
    RST = 0;
    for (int i = 0; i < 14; i++) run_op(vecs[i], $sformatf("vec%0d", i));
    @(negedge CLK);
    MemReadM = 1;
    ALUResultM = 32'h100;
    funct3M = 3'b010;
    wait_cycles = 3;
    @(negedge CLK);
    #1;
    chk("rst_mid_req_before", {31'b0, BusReq}, 32'd1);
    #1;
    RST = 1;
    #1;
    chk("rst_mid_busreq", {31'b0, BusReq}, 32'd0);
    chk("rst_mid_stall", {31'b0, StallM}, 32'd0);
    chk("rst_mid_readdata", ReadDataM, 32'd0);
    chk("rst_mid_busaddr", BusAddr, 32'd0);
    MemReadM = 0;
    @(negedge CLK);
    RST = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      chk("rst_after_no_req", {31'b0, BusReq}, 32'd0);
      chk("rst_after_no_stall", {31'b0, StallM}, 32'd0);
    end
    chk("rst_after_readdata", ReadDataM, 32'd0);
    rv = vecs[14];
    run_op(rv, "post_reset_load");
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the pipelined RISC-V core: sits directly downstream of the execute-to-memory pipeline register and consumes its memory-stage outputs (MemWriteM, MemReadM, ALUResultM, WriteDataM, funct3M). It translates each load/store into one or two word-aligned transactions on a req/ack data bus. It handles byte, half-word and word sizes, misaligned splits and load sign/zero extension. While an access is in flight it raises StallM to the hazard unit.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width (unit is defined for 32 only)
- FUNCT3_WIDTH, 3, width of funct3M

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-high reset
- MemReadM  input  1  load request from the M-stage register
- MemWriteM  input  1  store request from the M-stage register
- ALUResultM  input  32  byte address of the access
- WriteDataM  input  32  store data, right-aligned
- funct3M  input  3  size/extension: [1:0] 00=byte, 01=half, 10/11=word; [2]=1 zero-extend (loads only)
- ReadDataM  output  32  extended load result, registered
- StallM  output  1  combinational; freeze request to the hazard unit
- BusReq  output  1  registered transaction request
- BusWe  output  1  registered; 1=write, 0=read
- BusAddr  output  32  registered word address; [1:0] always 00
- BusWData  output  32  registered lane-aligned write data
- BusByteEn  output  4  registered byte enables (also driven for reads)
- BusRData  input  32  read data; valid in the cycle BusAck=1
- BusAck  input  1  completes the current transaction

## Operation
- FSM states: IDLE, REQ1, REQ2, DONE.
- Command: MemReadM|MemWriteM. If both are set, treat as a store and leave ReadDataM unchanged.
- Size in bytes is S = 1, 2 or 4. Offset is O = ALUResultM[1:0]. The access is split when O+S > 4.
- Store lanes:
  - 64-bit data D = {32'b0, WriteDataM masked to S bytes} << (8·O).
  - 8-bit enable E = ((1<<S)-1) << O.
  - The first transaction uses D[31:0]/E[3:0]. The second uses D[63:32]/E[7:4].
- Addresses:
  - First address A = {ALUResultM[31:2],2'b00}.
  - Second address is A+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- State transitions:
  - IDLE + command: latch the transaction and the split flag, load the bus registers for the first access, go to REQ1.
  - REQ1: BusReq=1. On BusAck, capture BusRData into low buffer L. If split, load the second access and go to REQ2; otherwise BusReq←0 and go to DONE.
  - REQ2: BusReq=1. On BusAck, capture BusRData into high buffer H, BusReq←0, go to DONE.
  - DONE: go to IDLE.
- Load result, registered on the transition into DONE:
  - R = ({H,L} >> 8·O) truncated to S bytes.
  - Sign-extend from bit 8S-1 when funct3M[2]=0; zero-extend otherwise.
  - For the unsplit case the H term is 0.
  - ReadDataM holds R until the next load completes.
- StallM = (IDLE & command) | REQ1 | REQ2. It is 0 in DONE, so the instruction advances at the end of the DONE cycle. Upstream holds the M-stage inputs stable while StallM=1.
- BusAddr, BusWe, BusWData and BusByteEn are stable whenever BusReq=1 and change only after BusAck.

## Timing
- Reset values: state=IDLE, BusReq=0, BusWe=0, BusAddr=0, BusWData=0, BusByteEn=0, ReadDataM=0. StallM=0 while RST=1.
- Reset mid-transaction: everything returns to reset values asynchronously. No second access is issued, and buffers L and H are discarded.
- Zero-wait aligned access:
  - Cycle T: IDLE, StallM=1.
  - Cycle T+1: REQ1, BusReq=1, BusAck=1, StallM=1.
  - Cycle T+2: DONE, StallM=0, ReadDataM valid.
  - Result: 2 stall cycles.
- Split access adds one cycle per extra transaction. Each wait state (BusAck=0) adds one cycle.
- BusAck may arrive in the first cycle BusReq=1. BusAck while BusReq=0 is ignored.
- Back-to-back commands: the next command is seen in the IDLE cycle after DONE. There are no dead cycles beyond that.

## Test plan
- Aligned word store: addr 0x100, data 0xDEADBEEF, funct3 010, zero-wait → one write at 0x100 with BE 1111, WData 0xDEADBEEF; StallM high for exactly 2 cycles.
- Byte loads: memory word at 0x200 = 0x80FF7F01, addr 0x202:
  - LB (funct3 000) → ReadDataM 0xFFFFFFFF.
  - LBU (funct3 100) → 0x000000FF.
  - LB at 0x203 → 0xFFFFFF80.
- Misaligned word load at 0x1FE: mem[0x1FC]=0x44332211, mem[0x200]=0x88776655 → two reads at 0x1FC then 0x200, BE 1100 then 0011; ReadDataM 0x66554433.
- Misaligned half store at 0xFFFFFFFF, data 0x0000ABCD:
  - Write 0xFFFFFFFC, BE 1000, WData 0xCD000000.
  - Then write 0x00000000, BE 0001, WData 0x000000AB (address wrap).
- Wait states and reset: word load with BusAck delayed 3 cycles → bus signals stable throughout, StallM high for 5 cycles. Repeat, asserting RST in REQ1 → BusReq and StallM drop immediately, no BusReq after release until a new command, ReadDataM=0.
